// File: rtl/idiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : idiv_iter
// Description : Radix-2 restoring integer divider for DIV/DIVU/REM/REMU,
//               one quotient bit per cycle, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module idiv_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int c_CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [1:0]         r_op_q, w_op_d;
    logic               r_a_neg_q, w_a_neg_d;
    logic               r_b_neg_q, w_b_neg_d;
    logic [XLEN-1:0]    r_quo_q, w_quo_d;
    logic [XLEN-1:0]    r_rem_q, w_rem_d;
    logic [XLEN-1:0]    r_dvs_q, w_dvs_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic [XLEN-1:0]    r_data_q, w_data_d;
    logic [TAG_W-1:0]   r_tag_q, w_tag_d;

    // Operand conditioning at accept; -MIN wraps to MIN, which is the correct
    // unsigned magnitude.
    logic            w_signed_in;
    logic            w_in_a_neg;
    logic            w_in_b_neg;
    logic [XLEN-1:0] w_in_a_mag;
    logic [XLEN-1:0] w_in_b_mag;
    logic            w_b_zero;
    logic            w_ovf;

    assign w_signed_in = ~in_op[0];
    assign w_in_a_neg  = w_signed_in & in_a[XLEN-1];
    assign w_in_b_neg  = w_signed_in & in_b[XLEN-1];
    assign w_in_a_mag  = w_in_a_neg ? -in_a : in_a;
    assign w_in_b_mag  = w_in_b_neg ? -in_b : in_b;
    assign w_b_zero    = (in_b == '0);
    assign w_ovf       = w_signed_in && (in_a == c_MIN_NEG) && (&in_b);

    // One restoring step: the shifted partial remainder needs XLEN+1 bits.
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;

    assign w_shift = {r_rem_q, r_quo_q[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs_q});
    assign w_sub   = w_shift[XLEN-1:0] - r_dvs_q;

    logic            w_neg_quo;
    logic            w_neg_rem;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_neg_quo = ~r_op_q[0] & (r_a_neg_q ^ r_b_neg_q);
    assign w_neg_rem = ~r_op_q[0] & r_a_neg_q;
    assign w_quo_fix = w_neg_quo ? -r_quo_q : r_quo_q;
    assign w_rem_fix = w_neg_rem ? -r_rem_q : r_rem_q;

    always_comb begin
        w_state_d = r_state_q;
        w_op_d    = r_op_q;
        w_a_neg_d = r_a_neg_q;
        w_b_neg_d = r_b_neg_q;
        w_quo_d   = r_quo_q;
        w_rem_d   = r_rem_q;
        w_dvs_d   = r_dvs_q;
        w_cnt_d   = r_cnt_q;
        w_data_d  = r_data_q;
        w_tag_d   = r_tag_q;

        case (r_state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    w_op_d    = in_op;
                    w_a_neg_d = w_in_a_neg;
                    w_b_neg_d = w_in_b_neg;
                    w_quo_d   = w_in_a_mag;
                    w_rem_d   = '0;
                    w_dvs_d   = w_in_b_mag;
                    w_cnt_d   = c_CNT_W'(XLEN - 1);
                    w_tag_d   = in_tag;
                    if (w_b_zero) begin
                        w_data_d  = in_op[1] ? in_a : '1;
                        w_state_d = ST_DONE;
                    end else if (w_ovf) begin
                        w_data_d  = in_op[1] ? '0 : in_a;
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                w_rem_d = w_ge ? w_sub : w_shift[XLEN-1:0];
                w_quo_d = {r_quo_q[XLEN-2:0], w_ge};
                w_cnt_d = r_cnt_q - 1'b1;
                if (r_cnt_q == '0) begin
                    w_state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                w_data_d  = r_op_q[1] ? w_rem_fix : w_quo_fix;
                w_state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Flush beats both a new accept and a consumer handshake.
        if (flush) begin
            w_state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_op_q    <= '0;
            r_a_neg_q <= 1'b0;
            r_b_neg_q <= 1'b0;
            r_quo_q   <= '0;
            r_rem_q   <= '0;
            r_dvs_q   <= '0;
            r_cnt_q   <= '0;
            r_data_q  <= '0;
            r_tag_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_op_q    <= w_op_d;
            r_a_neg_q <= w_a_neg_d;
            r_b_neg_q <= w_b_neg_d;
            r_quo_q   <= w_quo_d;
            r_rem_q   <= w_rem_d;
            r_dvs_q   <= w_dvs_d;
            r_cnt_q   <= w_cnt_d;
            r_data_q  <= w_data_d;
            r_tag_q   <= w_tag_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign busy      = (r_state_q != ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign out_data  = r_data_q;
    assign out_tag   = r_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_idiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_idiv_iter
// Description : Scoreboard bench for idiv_iter (XLEN=32, TAG_W=6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idiv_iter;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    idiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 0) return op[1] ? a : '1;
        case (op)
            2'b00:   return XLEN'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return XLEN'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one op at a negedge, wait for its result, check latency, optionally
    // hold backpressure for `hold` cycles, then consume it and compare.
    task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                          input int hold);
        int   n;
        exp_t e;
        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = (hold == 0);
        sb_q.push_back('{data: model(op, a, b), tag: tag});
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("latency", n, is_special(op, a, b) ? 0 : XLEN + 1);
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            for (int i = 0; i < hold; i++) begin
                chk("bp_valid", out_valid, 1);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_data", out_data, sb_q[0].data);
                chk("bp_tag", out_tag, sb_q[0].tag);
                @(negedge clock);
            end
            out_ready = 1'b1;
            e = sb_q.pop_front();
            chk("data", out_data, e.data);
            chk("tag", out_tag, e.tag);
        end
        @(posedge clock);
        @(negedge clock);
        chk("valid_drop", out_valid, 0);
        chk("back_idle", in_ready, 1);
    endtask

    initial begin
        int seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        @(negedge clock);

        // Directed operations
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 6'h11, 0);
        chk("div_m7_2_model", model(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 6'h12, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 6'h3F, 0);
        run_op(2'b11, 32'd100, 32'd7, 6'h05, 0);
        run_op(2'b00, 32'd5, 32'd0, 6'h21, 0);
        run_op(2'b10, 32'd5, 32'd0, 6'h22, 0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'h2A, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'h2B, 0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 6'h2C, 0);
        run_op(2'b10, 32'h8000_0000, 32'd3, 6'h2D, 0);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 6'h0E, 0);

        // Backpressure in DONE
        run_op(2'b11, 32'd1000, 32'd33, 6'h15, 10);

        // Random mix
        for (int k = 0; k < 8; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            run_op(rop, ra, rb, 6'($urandom_range(0, 63)), 0);
        end

        // Flush in BUSY: result discarded, no output ever
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_a     = 32'd100;
        in_b     = 32'd7;
        in_tag   = 6'h07;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        chk("flush_pre_busy", busy, 1);
        repeat (4) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clock);
        end
        chk("flush_no_valid", seen, 0);

        // Flush together with in_valid in IDLE: no accept
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = 2'b00;
        in_a     = 32'd5;
        in_b     = 32'd0;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_accept_busy", busy, 0);
        chk("flush_accept_valid", out_valid, 0);

        // Flush beats out_ready in DONE
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_op     = 2'b00;
        in_a      = 32'd9;
        in_b      = 32'd0;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        chk("done_valid", out_valid, 1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0;
        chk("done_flush_valid", out_valid, 0);
        chk("done_flush_ready", in_ready, 1);

        // Asynchronous reset mid-BUSY
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_a     = 32'd12345;
        in_b     = 32'd17;
        in_tag   = 6'h33;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_tag", out_tag, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_op(2'b11, 32'd100, 32'd7, 6'h01, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
